// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC + combinational ROM fetch into a DEPTH-entry {pc, inst} prefetch FIFO drained by decode.
// Define IF_PERF_CNT_EN to add saturating fetch_cnt/flush_cnt performance counters.
module if_fetch_queue #(
  parameter int A     = 8,
  parameter int IW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [A-1:0]             inst_addr_reset,
  output logic [A-1:0]             rom_addr,
  input  logic [IW-1:0]            rom_data,
  input  logic                     ctrl_branch,
  input  logic                     take_branch,
  input  logic [A-1:0]             inst_addr_in,
  input  logic                     halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_inst,
  output logic [A-1:0]             out_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]              fetch_cnt,
  output logic [15:0]              flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [A-1:0]  pc_q, pc_d, hpc_q, hpc_d;
  logic [IW-1:0] hin_q, hin_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          halted_q, redirect, pop, push;
  logic [A-1:0]  pcm [DEPTH];
  logic [IW-1:0] im [DEPTH];
  assign redirect  = ctrl_branch & take_branch;
  assign out_valid = count_q != '0;
  assign pop       = out_valid & out_ready & !redirect;
  assign push      = !halted_q & !halt & !redirect & ((count_q < CW'(DEPTH)) | pop);
  assign rom_addr  = pc_q;
  assign out_pc    = hpc_q;
  assign out_inst  = hin_q;
  assign halted    = halted_q;
  assign count     = count_q;
  // Head registers track the next head; if the queue would otherwise be empty it is the entry pushed now.
  always_comb begin
    remain  = count_q - CW'(pop);
    pc_d    = redirect ? inst_addr_in : push ? pc_q + A'(1) : pc_q;
    count_d = redirect ? '0 : remain + CW'(push);
    rd_d    = redirect ? '0 : rd_q + PW'(pop);
    wr_d    = redirect ? '0 : wr_q + PW'(push);
    hpc_d   = (count_d == '0) ? hpc_q : (remain == '0) ? pc_q : pcm[rd_d];
    hin_d   = (count_d == '0) ? hin_q : (remain == '0) ? rom_data : im[rd_d];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= inst_addr_reset;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      halted_q <= 1'b0;
      hpc_q    <= '0;
      hin_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      halted_q <= halted_q | halt;
      hpc_q    <= hpc_d;
      hin_q    <= hin_d;
      if (push) begin
        pcm[wr_q] <= pc_q;
        im[wr_q]  <= rom_data;
      end
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (redirect && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end
  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int A = 4, IW = 9, DEPTH = 4;
  logic clk = 0, reset = 0, ctrl_branch = 0, take_branch = 0, halt = 0, out_ready = 0;
  logic [A-1:0] inst_addr_reset = 0, inst_addr_in = 0, rom_addr, out_pc;
  logic [IW-1:0] rom_data, out_inst;
  logic out_valid, halted;
  logic [2:0] count;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif
  logic [IW-1:0] rom [16];
  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;
  if_fetch_queue #(.A(A), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inst_addr_reset(inst_addr_reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .ctrl_branch(ctrl_branch), .take_branch(take_branch), .inst_addr_in(inst_addr_in), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .halted(halted),
    .count(count)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );
  typedef struct packed { logic [A-1:0] pc; logic [IW-1:0] inst; } ent_t;
  ent_t q[$];
  ent_t mhead = '0;
  logic [A-1:0] mpc = '0;
  logic mhalted = 0;
  int checks = 0, passed = 0;
  task automatic tick();
    if (!reset) begin
      q.delete(); mpc = inst_addr_reset; mhalted = 0; mhead = '0;
    end else if (ctrl_branch && take_branch) begin
      q.delete(); mpc = inst_addr_in; mhalted = mhalted | halt;
    end else begin
      bit pop, fetch;
      pop = q.size() > 0 && out_ready;
      fetch = !mhalted && !halt && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back('{pc: mpc, inst: rom[mpc]});
        mpc = A'((int'(mpc) + 1) % (1 << A));
      end
      mhalted = mhalted | halt;
    end
    if (q.size() > 0) mhead = q[0];
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [21:0] expv();
    return {q.size() > 0, 3'(q.size()), mhalted, mpc, mhead};
  endfunction
  function automatic logic [21:0] obsv();
    return {out_valid, count, halted, rom_addr, out_pc, out_inst};
  endfunction
  task automatic test_reset();
    reset = 0; inst_addr_reset = 3; halt = 1; out_ready = 1; ctrl_branch = 1; take_branch = 1;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, out_inst, count, halted} !== '0) $display("FAIL reset_outputs got v=%b pc=%h inst=%h c=%0d h=%b exp all 0", out_valid, out_pc, out_inst, count, halted); else passed++;
    checks++;
    if (rom_addr !== 4'd3) $display("FAIL reset_pc got %h exp 3", rom_addr); else passed++;
    halt = 0; ctrl_branch = 0; take_branch = 0;
  endtask
  task automatic test_stream();
    reset = 1; out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obsv() !== expv() || count > 1) $display("FAIL stream cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
  endtask
  task automatic test_backpressure();
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obsv() !== expv()) $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
    checks++;
    if (count !== 3'(DEPTH)) $display("FAIL backpressure_full got %0d exp %0d", count, DEPTH); else passed++;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obsv() !== expv()) $display("FAIL drain_order cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
  endtask
  task automatic test_redirect();
    out_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    ctrl_branch = 1; take_branch = 1; inst_addr_in = 1;
    tick();
    ctrl_branch = 0; take_branch = 0;
    checks++;
    if (count !== 0 || out_valid !== 0 || rom_addr !== 4'd1) $display("FAIL redirect_flush got c=%0d v=%b pc=%h exp 0 0 1", count, out_valid, rom_addr); else passed++;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obsv() !== expv()) $display("FAIL redirect_stream cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
    ctrl_branch = 1; inst_addr_in = 9;
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obsv() !== expv()) $display("FAIL fallthrough cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
    ctrl_branch = 0;
  endtask
  task automatic test_halt();
    out_ready = 1;
    for (int i = 0; i < 20 && mpc != 7; i++) tick();
    checks++;
    if (rom_addr !== 4'd7) $display("FAIL halt_reach_pc got %h exp 7", rom_addr); else passed++;
    halt = 1;
    tick();
    halt = 0;
    checks++;
    if (halted !== 1 || obsv() !== expv()) $display("FAIL halt_latch got=%h exp=%h", obsv(), expv()); else passed++;
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obsv() !== expv()) $display("FAIL halt_drain cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
    out_ready = 1;
    repeat (4) tick();
    checks++;
    if (count !== 0 || rom_addr !== 4'd7) $display("FAIL halt_empty got c=%0d pc=%h exp 0 7", count, rom_addr); else passed++;
    ctrl_branch = 1; take_branch = 1; inst_addr_in = 12;
    tick();
    ctrl_branch = 0; take_branch = 0;
    repeat (2) tick();
    checks++;
    if (obsv() !== expv() || rom_addr !== 4'd12 || count !== 0) $display("FAIL halt_redirect got=%h exp=%h", obsv(), expv()); else passed++;
    reset = 0; inst_addr_reset = 5;
    tick();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obsv() !== expv() || halted !== 0) $display("FAIL halt_resume cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
  endtask
  task automatic test_wrap();
    logic [A-1:0] seq [4];
    seq[0] = 14; seq[1] = 15; seq[2] = 0; seq[3] = 1;
    reset = 0; inst_addr_reset = 14;
    tick();
    reset = 1; out_ready = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1 || out_pc !== seq[i] || obsv() !== expv()) $display("FAIL wrap cyc=%0d got pc=%h exp %h", i, out_pc, seq[i]); else passed++;
      tick();
    end
    out_ready = 0;
    repeat (5) tick();
    reset = 0;
    tick();
    reset = 1;
    checks++;
    if (count !== 0 || out_valid !== 0 || rom_addr !== 4'd14) $display("FAIL mid_reset got c=%0d v=%b pc=%h exp 0 0 e", count, out_valid, rom_addr); else passed++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) >= 3);
      inst_addr_reset = 4'($urandom);
      ctrl_branch = ($urandom_range(0, 9) < 2);
      take_branch = 1'($urandom_range(0, 1));
      inst_addr_in = 4'($urandom);
      halt = ($urandom_range(0, 99) < 2);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
      checks++;
      if (obsv() !== expv()) $display("FAIL random cyc=%0d got=%h exp=%h", i, obsv(), expv()); else passed++;
    end
    reset = 1; ctrl_branch = 0; take_branch = 0; halt = 0;
  endtask
`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    reset = 0; inst_addr_reset = 0; out_ready = 1;
    tick();
    reset = 1;
    repeat (20) tick();
    ctrl_branch = 1; take_branch = 1; inst_addr_in = 2;
    repeat (2) tick();
    ctrl_branch = 0; take_branch = 0;
    checks++;
    if (fetch_cnt !== 16'd20 || flush_cnt !== 16'd2) $display("FAIL perf_counts got f=%0d r=%0d exp 20 2", fetch_cnt, flush_cnt); else passed++;
    force dut.fetch_cnt_q = 16'hFFFE;
    #1;
    release dut.fetch_cnt_q;
    repeat (3) tick();
    checks++;
    if (fetch_cnt !== 16'hFFFF) $display("FAIL perf_saturate got %h exp ffff", fetch_cnt); else passed++;
  endtask
`endif
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = IW'($urandom);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
